// File: rtl/bpf_pkt_sched_pkg.sv
// Shared definitions for the BPF packet scheduler: per-buffer state encodings
// and the default packet-length width.
package bpf_pkt_sched_pkg;

    localparam int PLEN_WIDTH_DEF = 10;

    localparam logic [2:0] ST_EMPTY = 3'd0;
    localparam logic [2:0] ST_SNOOP = 3'd1;
    localparam logic [2:0] ST_READY = 3'd2;
    localparam logic [2:0] ST_CPU   = 3'd3;
    localparam logic [2:0] ST_ACC   = 3'd4;
    localparam logic [2:0] ST_REJ   = 3'd5;

endpackage

// File: rtl/bpf_ring_ptr.sv
// Modulo-NUM_BUFS ring pointer; advances by one on adv and wraps to 0 after
// NUM_BUFS-1, so non-power-of-two rings work.
module bpf_ring_ptr #(
    parameter int NUM_BUFS = 3,
    parameter int BUF_W    = $clog2(NUM_BUFS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    output logic [BUF_W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (ptr == BUF_W'(NUM_BUFS - 1)) ? '0 : ptr + BUF_W'(1);
        end
    end

endmodule

// File: rtl/bpf_pkt_sched.sv
// Ring scheduler passing packet buffers snooper -> BPF CPU -> forwarder in
// strict ring order; gates the CPU through cpu_rst and counts rejects/timeouts.
//
// state    | meaning
// EMPTY    | free, waiting for the snooper pointer
// SNOOP    | owned by the snooper, being filled
// READY    | filled, waiting for the CPU
// CPU      | being filtered
// ACC      | accepted, offered / waiting for the forwarder
// REJ      | rejected or timed out, freed by the forward stage
module bpf_pkt_sched
    import bpf_pkt_sched_pkg::*;
#(
    parameter int NUM_BUFS   = 3,
    parameter int PLEN_WIDTH = PLEN_WIDTH_DEF,
    parameter int MAX_CYCLES = 1024,
    parameter int CNT_WIDTH  = 32,
    localparam int BUF_W     = $clog2(NUM_BUFS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  sn_rdy,
    output logic [BUF_W-1:0]      sn_buf,
    input  logic                  sn_done,
    input  logic [PLEN_WIDTH-1:0] sn_len,
    output logic                  cpu_rst,
    output logic [BUF_W-1:0]      cpu_buf,
    output logic [PLEN_WIDTH-1:0] cpu_plen,
    input  logic                  cpu_acc,
    input  logic                  cpu_rej,
    output logic                  fwd_valid,
    output logic [BUF_W-1:0]      fwd_buf,
    output logic [PLEN_WIDTH-1:0] fwd_len,
    input  logic                  fwd_done,
    output logic [CNT_WIDTH-1:0]  rej_cnt,
    output logic [CNT_WIDTH-1:0]  to_cnt
);

    localparam int CYC_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    logic [2:0]            state [NUM_BUFS];
    logic [PLEN_WIDTH-1:0] len   [NUM_BUFS];
    logic [BUF_W-1:0]      s, c, f;
    logic [CYC_W-1:0]      cyc;

    logic sn_take, cpu_go, cpu_res_acc, cpu_res_rej, cpu_tmo, fwd_take, fwd_drop;
    logic s_adv, c_adv, f_adv;

    // Simultaneous accept and reject resolves to reject; a result beats a timeout.
    always_comb begin
        sn_take     = sn_done && sn_rdy;
        cpu_go      = cpu_rst && (state[c] == ST_READY);
        cpu_res_rej = !cpu_rst && cpu_rej;
        cpu_res_acc = !cpu_rst && cpu_acc && !cpu_rej;
        cpu_tmo     = !cpu_rst && !cpu_acc && !cpu_rej && (MAX_CYCLES > 0)
                      && (cyc == CYC_W'(MAX_CYCLES - 1));
        fwd_take    = fwd_done && fwd_valid;
        fwd_drop    = (state[f] == ST_REJ);
        s_adv       = sn_take;
        c_adv       = cpu_res_acc || cpu_res_rej || cpu_tmo;
        f_adv       = fwd_take || fwd_drop;
    end

    assign sn_buf = s;

    bpf_ring_ptr #(.NUM_BUFS(NUM_BUFS), .BUF_W(BUF_W)) u_ptr_s (
        .clk(clk), .rst_n(rst_n), .adv(s_adv), .ptr(s)
    );
    bpf_ring_ptr #(.NUM_BUFS(NUM_BUFS), .BUF_W(BUF_W)) u_ptr_c (
        .clk(clk), .rst_n(rst_n), .adv(c_adv), .ptr(c)
    );
    bpf_ring_ptr #(.NUM_BUFS(NUM_BUFS), .BUF_W(BUF_W)) u_ptr_f (
        .clk(clk), .rst_n(rst_n), .adv(f_adv), .ptr(f)
    );

    // Each stage only touches a buffer in its own state, so writes never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                state[i] <= ST_EMPTY;
                len[i]   <= '0;
            end
        end else begin
            if (state[s] == ST_EMPTY) begin
                state[s] <= ST_SNOOP;
            end else if (sn_take) begin
                state[s] <= ST_READY;
                len[s]   <= sn_len;
            end

            if (cpu_go) begin
                state[c] <= ST_CPU;
            end else if (cpu_res_acc) begin
                state[c] <= ST_ACC;
            end else if (cpu_res_rej || cpu_tmo) begin
                state[c] <= ST_REJ;
            end

            if (f_adv) begin
                state[f] <= ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sn_rdy    <= 1'b0;
            cpu_rst   <= 1'b1;
            cpu_buf   <= '0;
            cpu_plen  <= '0;
            cyc       <= '0;
            fwd_valid <= 1'b0;
            fwd_buf   <= '0;
            fwd_len   <= '0;
            rej_cnt   <= '0;
            to_cnt    <= '0;
        end else begin
            sn_rdy <= sn_take ? 1'b0 : (state[s] == ST_SNOOP);

            // cpu_go requires cpu_rst==1, so every dispatch follows a reset cycle.
            if (cpu_go) begin
                cpu_rst  <= 1'b0;
                cpu_buf  <= c;
                cpu_plen <= len[c];
                cyc      <= '0;
            end else if (c_adv) begin
                cpu_rst <= 1'b1;
            end else if (!cpu_rst) begin
                cyc <= cyc + CYC_W'(1);
            end

            if (cpu_tmo) begin
                to_cnt <= to_cnt + CNT_WIDTH'(1);
            end

            if (fwd_take) begin
                fwd_valid <= 1'b0;
            end else if (!fwd_valid && (state[f] == ST_ACC)) begin
                fwd_valid <= 1'b1;
                fwd_buf   <= f;
                fwd_len   <= len[f];
            end

            if (fwd_drop) begin
                rej_cnt <= rej_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_bpf_pkt_sched.sv
// Bench for bpf_pkt_sched: directed timing steps, then randomized traffic
// checked against a queue model of ring order, verdicts and counters.
module tb_bpf_pkt_sched;

   localparam int NB = 3;
   localparam int PW = 10;
   localparam int MC = 100;
   localparam int CW = 32;
   localparam int BW = 2;
   localparam int NP = 60;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          sn_rdy;
   logic [BW-1:0] sn_buf;
   logic          sn_done;
   logic [PW-1:0] sn_len;
   logic          cpu_rst;
   logic [BW-1:0] cpu_buf;
   logic [PW-1:0] cpu_plen;
   logic          cpu_acc;
   logic          cpu_rej;
   logic          fwd_valid;
   logic [BW-1:0] fwd_buf;
   logic [PW-1:0] fwd_len;
   logic          fwd_done;
   logic [CW-1:0] rej_cnt;
   logic [CW-1:0] to_cnt;

   always #5 clk = ~clk;

   bpf_pkt_sched #(
      .NUM_BUFS(NB), .PLEN_WIDTH(PW), .MAX_CYCLES(MC), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .sn_rdy(sn_rdy), .sn_buf(sn_buf), .sn_done(sn_done), .sn_len(sn_len),
      .cpu_rst(cpu_rst), .cpu_buf(cpu_buf), .cpu_plen(cpu_plen),
      .cpu_acc(cpu_acc), .cpu_rej(cpu_rej),
      .fwd_valid(fwd_valid), .fwd_buf(fwd_buf), .fwd_len(fwd_len), .fwd_done(fwd_done),
      .rej_cnt(rej_cnt), .to_cnt(to_cnt)
   );

   typedef struct { int b; int l; } pkt_t;

   int   n_chk  = 0;
   int   n_fail = 0;
   int   exp_s  = 0;
   int   exp_c  = 0;
   int   m_rej  = 0;
   int   m_to   = 0;
   pkt_t rdy_q[$];
   pkt_t acc_q[$];

   task automatic chk(input string tag, input bit ok);
      n_chk++;
      assert (ok) else begin
         n_fail++;
         $error("FAIL %s", tag);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input int l);
      for (int i = 0; i < 200 && sn_rdy !== 1'b1; i++) tick();
      chk("send_rdy", sn_rdy === 1'b1);
      chk("send_buf", sn_buf === exp_s);
      sn_len  = PW'(l);
      sn_done = 1'b1;
      tick();
      sn_done = 1'b0;
      chk("send_drop", sn_rdy === 1'b0);
      exp_s = (exp_s + 1) % NB;
   endtask

   task automatic cpu_wait(input int l);
      for (int i = 0; i < 200 && cpu_rst !== 1'b0; i++) tick();
      chk("disp_rst", cpu_rst === 1'b0);
      chk("disp_buf", cpu_buf === exp_c);
      chk("disp_plen", cpu_plen === l);
   endtask

   task automatic cpu_res(input logic a, input logic r);
      cpu_acc = a;
      cpu_rej = r;
      tick();
      cpu_acc = 1'b0;
      cpu_rej = 1'b0;
      chk("res_rst", cpu_rst === 1'b1);
      exp_c = (exp_c + 1) % NB;
   endtask

   task automatic fwd_drain(input int b, input int l);
      for (int i = 0; i < 200 && fwd_valid !== 1'b1; i++) tick();
      chk("fwd_valid", fwd_valid === 1'b1);
      chk("fwd_buf", fwd_buf === b);
      chk("fwd_len", fwd_len === l);
      fwd_done = 1'b1;
      tick();
      fwd_done = 1'b0;
      chk("fwd_drop", fwd_valid === 1'b0);
   endtask

   initial begin
      int   seen;
      int   n;
      int   cyc;
      int   sent;
      int   run;
      int   r;
      int   l;
      bit   busy;
      bit   pend;
      bit   pend_rej;
      bit   silent;
      bit   offer_chk;
      pkt_t cur;

      rst_n = 1'b0; sn_done = 1'b0; sn_len = '0;
      cpu_acc = 1'b0; cpu_rej = 1'b0; fwd_done = 1'b0;
      repeat (3) tick();
      chk("rst_sn_rdy", sn_rdy === 1'b0);
      chk("rst_sn_buf", sn_buf === 0);
      chk("rst_cpu_rst", cpu_rst === 1'b1);
      chk("rst_cpu_buf", cpu_buf === 0);
      chk("rst_cpu_plen", cpu_plen === 0);
      chk("rst_fwd_valid", fwd_valid === 1'b0);
      chk("rst_fwd_buf", fwd_buf === 0);
      chk("rst_fwd_len", fwd_len === 0);
      chk("rst_rej_cnt", rej_cnt === 0);
      chk("rst_to_cnt", to_cnt === 0);

      rst_n = 1'b1;
      tick();
      chk("sn_rdy_edge1", sn_rdy === 1'b0);
      tick();
      chk("sn_rdy_edge2", sn_rdy === 1'b1);
      chk("sn_buf_edge2", sn_buf === 0);

      sn_len = PW'(64); sn_done = 1'b1;
      tick();
      sn_done = 1'b0;
      chk("first_sn_drop", sn_rdy === 1'b0);
      chk("first_cpu_hold", cpu_rst === 1'b1);
      tick();
      chk("first_cpu_rst", cpu_rst === 1'b0);
      chk("first_cpu_buf", cpu_buf === 0);
      chk("first_cpu_plen", cpu_plen === 64);
      chk("first_sn_idle", sn_rdy === 1'b0);
      tick();
      chk("first_sn_back", sn_rdy === 1'b1);
      chk("first_sn_buf", sn_buf === 1);
      cpu_acc = 1'b1;
      tick();
      cpu_acc = 1'b0;
      chk("first_acc_rst", cpu_rst === 1'b1);
      chk("first_fwd_early", fwd_valid === 1'b0);
      tick();
      chk("first_fwd_valid", fwd_valid === 1'b1);
      chk("first_fwd_buf", fwd_buf === 0);
      chk("first_fwd_len", fwd_len === 64);
      repeat (3) tick();
      chk("first_fwd_hold", fwd_valid === 1'b1);
      fwd_done = 1'b1;
      tick();
      fwd_done = 1'b0;
      chk("first_fwd_drop", fwd_valid === 1'b0);
      exp_s = 1;
      exp_c = 1;

      // reject then accept: only the accepted one is offered
      send_pkt(10);
      send_pkt(20);
      cpu_wait(10);
      cpu_res(1'b0, 1'b1);
      seen = 0;
      repeat (4) begin tick(); if (fwd_valid) seen++; end
      chk("rej_no_fwd", seen === 0);
      chk("rej_cnt_1", rej_cnt === 1);
      cpu_wait(20);
      cpu_res(1'b1, 1'b0);
      fwd_drain(2, 20);
      chk("rej_cnt_still_1", rej_cnt === 1);

      // ring full back-pressure
      send_pkt(100);
      cpu_wait(100);
      cpu_res(1'b1, 1'b0);
      send_pkt(200);
      cpu_wait(200);
      cpu_res(1'b1, 1'b0);
      send_pkt(300);
      cpu_wait(300);
      cpu_res(1'b1, 1'b0);
      seen = 0;
      repeat (10) begin tick(); if (sn_rdy) seen++; end
      chk("full_sn_rdy", seen === 0);
      fwd_drain(0, 100);
      tick();
      chk("full_sn_idle", sn_rdy === 1'b0);
      tick();
      chk("full_sn_rdy_back", sn_rdy === 1'b1);
      chk("full_sn_buf", sn_buf === 0);
      fwd_drain(1, 200);
      fwd_drain(2, 300);

      // silent CPU times out after exactly MC low cycles
      send_pkt(55);
      cpu_wait(55);
      n = 1;
      for (int i = 0; i < 300 && cpu_rst == 1'b0; i++) begin
         tick();
         if (cpu_rst == 1'b0) n++;
      end
      exp_c = (exp_c + 1) % NB;
      chk("tmo_low_cycles", n === MC);
      chk("tmo_to_cnt", to_cnt === 1);
      tick();
      tick();
      chk("tmo_rej_cnt", rej_cnt === 2);

      // simultaneous accept and reject
      send_pkt(77);
      cpu_wait(77);
      cpu_res(1'b1, 1'b1);
      seen = 0;
      repeat (5) begin tick(); if (fwd_valid) seen++; end
      chk("both_no_fwd", seen === 0);
      chk("both_rej_cnt", rej_cnt === 3);
      chk("both_to_cnt", to_cnt === 1);

      // randomized traffic against the queue model
      m_rej = 3; m_to = 1;
      cyc = 0; sent = 0; run = 0;
      busy = 0; pend = 0; pend_rej = 0; silent = 0; offer_chk = 0;
      cur = '{0, 0};
      while ((sent < NP || rdy_q.size() > 0 || busy || acc_q.size() > 0) && cyc < 30000) begin
         if (busy) begin
            if (pend) begin
               chk("rnd_res_rst", cpu_rst === 1'b1);
               busy = 0; pend = 0;
               exp_c = (exp_c + 1) % NB;
               if (pend_rej) m_rej++;
               else acc_q.push_back(cur);
            end else if (run == MC) begin
               chk("rnd_tmo_rst", cpu_rst === 1'b1);
               busy = 0;
               exp_c = (exp_c + 1) % NB;
               m_rej++; m_to++;
            end else begin
               chk("rnd_run_rst", cpu_rst === 1'b0);
               run++;
            end
         end else if (cpu_rst == 1'b0) begin
            chk("rnd_disp_queued", rdy_q.size() > 0);
            if (rdy_q.size() > 0) cur = rdy_q.pop_front();
            chk("rnd_disp_buf", cpu_buf === cur.b);
            chk("rnd_disp_plen", cpu_plen === cur.l);
            busy = 1; run = 1;
            silent = ($urandom_range(5) == 0);
         end

         if (fwd_valid && !offer_chk) begin
            chk("rnd_fwd_queued", acc_q.size() > 0);
            if (acc_q.size() > 0) begin
               chk("rnd_fwd_buf", fwd_buf === acc_q[0].b);
               chk("rnd_fwd_len", fwd_len === acc_q[0].l);
            end
            offer_chk = 1;
         end

         sn_done = 1'b0; cpu_acc = 1'b0; cpu_rej = 1'b0; fwd_done = 1'b0;
         if (sent < NP && $urandom_range(2) == 0) begin
            if (sn_rdy) begin
               chk("rnd_sn_buf", sn_buf === exp_s);
               l = int'($urandom_range(1023));
               sn_len = PW'(l);
               sn_done = 1'b1;
               rdy_q.push_back('{exp_s, l});
               exp_s = (exp_s + 1) % NB;
               sent++;
            end else if ($urandom_range(3) == 0) begin
               sn_len = PW'($urandom);
               sn_done = 1'b1;
            end
         end
         if (busy && !pend && !silent) begin
            r = int'($urandom_range(31));
            if (r < 4) begin cpu_acc = 1'b1; pend = 1; pend_rej = 0; end
            else if (r < 6) begin cpu_rej = 1'b1; pend = 1; pend_rej = 1; end
            else if (r == 6) begin cpu_acc = 1'b1; cpu_rej = 1'b1; pend = 1; pend_rej = 1; end
         end else if (!busy && $urandom_range(7) == 0) begin
            cpu_acc = 1'($urandom_range(1));
            cpu_rej = !cpu_acc;
         end
         if (fwd_valid && offer_chk && $urandom_range(2) == 0) begin
            fwd_done = 1'b1;
            if (acc_q.size() > 0) void'(acc_q.pop_front());
            offer_chk = 0;
         end else if (!fwd_valid && $urandom_range(7) == 0) begin
            fwd_done = 1'b1;
         end
         tick();
         cyc++;
      end
      sn_done = 1'b0; cpu_acc = 1'b0; cpu_rej = 1'b0; fwd_done = 1'b0;
      chk("rnd_budget", cyc < 30000);
      repeat (3) tick();
      chk("rnd_rej_cnt", rej_cnt === m_rej);
      chk("rnd_to_cnt", to_cnt === m_to);
      chk("rnd_acc_left", acc_q.size() === 0);

      // asynchronous reset in the middle of a packet
      send_pkt(33);
      cpu_wait(33);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_sn_rdy", sn_rdy === 1'b0);
      chk("mid_sn_buf", sn_buf === 0);
      chk("mid_cpu_rst", cpu_rst === 1'b1);
      chk("mid_cpu_buf", cpu_buf === 0);
      chk("mid_cpu_plen", cpu_plen === 0);
      chk("mid_fwd_valid", fwd_valid === 1'b0);
      chk("mid_fwd_len", fwd_len === 0);
      chk("mid_rej_cnt", rej_cnt === 0);
      chk("mid_to_cnt", to_cnt === 0);
      tick();
      tick();
      rst_n = 1'b1;
      exp_s = 0;
      exp_c = 0;
      tick();
      chk("restart_edge1", sn_rdy === 1'b0);
      tick();
      chk("restart_edge2", sn_rdy === 1'b1);
      chk("restart_sn_buf", sn_buf === 0);
      send_pkt(44);
      cpu_wait(44);
      cpu_res(1'b1, 1'b0);
      fwd_drain(0, 44);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
